mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
//  Target side of the SLC-3 CPU memory interface: accepts mem_mem_ena/mem_wr_ena requests from the
//  control unit, drives the synchronous on-chip BRAM (address reg + output reg), maps IO_ADDR to the
//  switches (read) and hex display register (write), and returns read data on the cycle the CPU's
//  last wait state latches MDR. Sits between the cpu datapath (MAR/MDR) and BRAM/board I/O.
// PARAMETERS
//  ADDR_W   10       BRAM address width (depth 2**ADDR_W words x 16b)
//  RD_LAT   2        BRAM read latency in cycles (addr reg + output reg); must be >= 1
//  IO_ADDR  16'hFFFF memory-mapped I/O address (read=sw_i, write=hex_display_o)
// PORTS
//  clk            in   1       system clock, all state on rising edge
//  reset          in   1       asynchronous, active-high
//  mem_mem_ena    in   1       CPU memory request enable
//  mem_wr_ena     in   1       1=write, 0=read; sampled with mem_mem_ena
//  mem_addr       in   16      MAR value
//  mem_wdata      in   16      MDR value for writes
//  mem_rdata      out  16      read data to MDR mux
//  mem_rdy        out  1       1-cycle pulse: access complete, mem_rdata valid
//  sw_i           in   16      board switches (asynchronous)
//  hex_display_o  out  16      register written by stores to IO_ADDR
//  bram_ena       out  1       BRAM enable
//  bram_we        out  1       BRAM write enable
//  bram_addr      out  ADDR_W  BRAM address
//  bram_wdata     out  16      BRAM write data
//  bram_rdata     in   16      BRAM output-register data
// BEHAVIOUR
//  Reset (async, asserted): state=IDLE, cnt=0, mem_rdy=0, hex_display_o=0, sw sync flops=0,
//   io_sel=0; bram_ena/bram_we forced 0 while reset high. BRAM contents untouched.
//  FSM IDLE/BUSY. IDLE: request = mem_mem_ena. On request at cycle T (accepted at edge ending T):
//   - is_io = (mem_addr==IO_ADDR); io_sel <= is_io; cnt <= RD_LAT-1 (0 => no count); -> BUSY.
//   - bram_ena = mem_mem_ena & ~is_io, bram_we = bram_ena & mem_wr_ena, combinational in IDLE only.
//   - bram_addr = mem_addr[ADDR_W-1:0] (upper bits ignored: aliasing), bram_wdata = mem_wdata.
//   - IO write: hex_display_o <= mem_wdata at edge ending T. IO read: no BRAM access.
//  BUSY: bram_ena=bram_we=0; mem_mem_ena/mem_wr_ena ignored (CPU holds them through its wait states,
//   these are NOT new requests). cnt decrements; mem_rdy=1 in the cycle cnt==0, i.e. cycle T+RD_LAT;
//   next edge -> IDLE. Default RD_LAT=2: accept T, rdy at T+2, IDLE at T+3 -> matches 3 wait states.
//  mem_rdata (combinational): io_sel ? sw_sync : bram_rdata; valid only while mem_rdy=1, don't-care
//   otherwise. sw_sync = 2-flop synchronizer of sw_i, value at the cycle mem_rdy is high.
//  Writes also complete with mem_rdy at T+RD_LAT (uniform timing); mem_rdata don't-care for writes.
//  Back-to-back: mem_mem_ena high in IDLE at T+RD_LAT+1 is a fresh request; max 1 access per
//   RD_LAT+1 cycles. Read following write to same addr returns written value.
//  Reset mid-BUSY: aborts immediately, no mem_rdy; a BRAM write already issued stays committed.
// TESTING
//  1 Reset: hold reset, toggle clk -> mem_rdy=0, hex_display_o=0, bram_ena=0; release -> IDLE.
//  2 Write 16'h1234 to 16'h0005 then read 16'h0005 (mem_mem_ena held 3 cycles each) -> bram_we=1
//    only in cycle T, mem_rdy at T+2, read mem_rdata=16'h1234 while mem_rdy=1.
//  3 Write 16'hBEEF to IO_ADDR -> hex_display_o=16'hBEEF after edge ending T, bram_ena never 1.
//  4 sw_i=16'h00A5, read IO_ADDR -> mem_rdata=16'h00A5 at T+2, no BRAM access.
//  5 Alias: write 16'h7777 to 16'h0403 (ADDR_W=10), read 16'h0003 -> 16'h7777.
//  6 Assert reset at T+1 of a read -> no mem_rdy; after release, new read completes normally at T'+2.

Source files
------------

// File: rtl/mem_io_responder.sv
// Target side of the SLC-3 memory interface: sequences one BRAM or I/O access per request
// and pulses mem_rdy when the CPU's final wait state is due to latch MDR.
module mem_io_responder #(
  parameter int          ADDR_W  = 10,
  parameter int          RD_LAT  = 2,
  parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_mem_ena,
  input  logic              mem_wr_ena,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata,
  output logic              mem_rdy,
  input  logic [15:0]       sw_i,
  output logic [15:0]       hex_display_o,
  output logic              bram_ena,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [15:0]       bram_wdata,
  input  logic [15:0]       bram_rdata,
  output logic [0:0]        dbg_state_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LAT - 1);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             io_sel_q, io_sel_d;
  logic [15:0]      hex_q, hex_d;
  logic [15:0]      sw_meta_q, sw_sync_q;
  logic             is_io;

  assign is_io         = (mem_addr == IO_ADDR);
  assign bram_addr     = mem_addr[ADDR_W-1:0];
  assign bram_wdata    = mem_wdata;
  assign hex_display_o = hex_q;
  assign dbg_state_o   = state_q;
  assign mem_rdata     = io_sel_q ? sw_sync_q : bram_rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    io_sel_d = io_sel_q;
    hex_d    = hex_q;
    mem_rdy  = 1'b0;
    bram_ena = 1'b0;
    bram_we  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_mem_ena) begin
          io_sel_d = is_io;
          cnt_d    = CNT_INIT;
          state_d  = S_BUSY;
          bram_ena = ~is_io;
          bram_we  = ~is_io & mem_wr_ena;
          if (is_io && mem_wr_ena) hex_d = mem_wdata;
        end
      end
      S_BUSY: begin
        // Request lines are held by the CPU through its wait states; only the counter matters here.
        if (cnt_q == '0) begin
          mem_rdy = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Async reset returns state to IDLE, but IDLE decoding is combinational on the request.
    if (reset) begin
      bram_ena = 1'b0;
      bram_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      io_sel_q  <= 1'b0;
      hex_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      io_sel_q  <= io_sel_d;
      hex_q     <= hex_d;
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: BRAM behavioural model, reference memory/hex model,
// directed and randomized accesses with per-cycle handshake checks.
module tb_mem_io_responder;

  localparam int ADDR_W = 10;
  localparam int RD_LAT = 2;
  localparam logic [15:0] IO_ADDR = 16'hFFFF;

  logic              clk, reset;
  logic              mem_mem_ena, mem_wr_ena;
  logic [15:0]       mem_addr, mem_wdata, mem_rdata;
  logic              mem_rdy;
  logic [15:0]       sw_i, hex_display_o;
  logic              bram_ena, bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [15:0]       bram_wdata, bram_rdata;
  logic [0:0]        dbg_state_o;

  int checks = 0;
  int errors = 0;

  // Reference model: word memory indexed by aliased address, plus expected display register.
  logic [15:0] ref_mem [1024];
  logic [15:0] exp_hex;

  // Environment BRAM: address register then output register.
  logic [15:0]       bram_mem [1024];
  logic [ADDR_W-1:0] bram_addr_r;

  mem_io_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .IO_ADDR(IO_ADDR)) dut (
    .clk(clk), .reset(reset),
    .mem_mem_ena(mem_mem_ena), .mem_wr_ena(mem_wr_ena),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .sw_i(sw_i), .hex_display_o(hex_display_o),
    .bram_ena(bram_ena), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_rdata(bram_rdata),
    .dbg_state_o(dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bram_ena) begin
      if (bram_we) bram_mem[bram_addr] <= bram_wdata;
      bram_addr_r <= bram_addr;
    end
    bram_rdata <= bram_mem[bram_addr_r];
  end

  // One full access: request held RD_LAT+1 cycles, every cycle checked.
  task automatic access(input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input bit gap, input string name);
    bit          io;
    logic [15:0] exp_rd;
    logic [15:0] hex_before;
    io = (addr == IO_ADDR);
    exp_rd = io ? sw_i : ref_mem[addr % 1024];
    hex_before = exp_hex;
    if (gap) begin
      @(posedge clk); #1;
    end
    mem_mem_ena = 1'b1; mem_wr_ena = wr; mem_addr = addr; mem_wdata = wdata;
    for (int k = 0; k <= RD_LAT; k++) begin
      @(negedge clk);
      checks++;
      if (bram_ena !== (k == 0 && !io)) begin
        errors++; $display("FAIL %s bram_ena cyc%0d got %b want %b", name, k, bram_ena, (k == 0 && !io));
      end
      checks++;
      if (bram_we !== (k == 0 && !io && wr)) begin
        errors++; $display("FAIL %s bram_we cyc%0d got %b want %b", name, k, bram_we, (k == 0 && !io && wr));
      end
      checks++;
      if (mem_rdy !== (k == RD_LAT)) begin
        errors++; $display("FAIL %s mem_rdy cyc%0d got %b want %b", name, k, mem_rdy, (k == RD_LAT));
      end
      checks++;
      if (hex_display_o !== ((k >= 1 && io && wr) ? wdata : hex_before)) begin
        errors++; $display("FAIL %s hex cyc%0d got %h want %h", name, k, hex_display_o,
                           ((k >= 1 && io && wr) ? wdata : hex_before));
      end
      if (k == RD_LAT && !wr) begin
        checks++;
        if (mem_rdata !== exp_rd) begin
          errors++; $display("FAIL %s rdata addr %h got %h want %h", name, addr, mem_rdata, exp_rd);
        end
      end
      @(posedge clk); #1;
    end
    mem_mem_ena = 1'b0; mem_wr_ena = 1'b0;
    if (wr) begin
      if (io) exp_hex = wdata;
      else    ref_mem[addr % 1024] = wdata;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_mem_ena = 1'b1; mem_wr_ena = 1'b1; mem_addr = 16'h0005; mem_wdata = 16'hDEAD;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", mem_rdy); end
    checks++;
    if (hex_display_o !== 16'h0) begin errors++; $display("FAIL reset_hex got %h want 0000", hex_display_o); end
    checks++;
    if (bram_ena !== 1'b0 || bram_we !== 1'b0) begin
      errors++; $display("FAIL reset_bram got ena %b we %b want 0 0", bram_ena, bram_we);
    end
    mem_mem_ena = 1'b0; mem_wr_ena = 1'b0;
    reset = 1'b0;
    exp_hex = 16'h0;
    @(negedge clk);
    checks++;
    if (mem_rdy !== 1'b0) begin errors++; $display("FAIL post_reset_rdy got %b want 0", mem_rdy); end
  endtask

  task automatic test_write_read();
    access(1'b1, 16'h0005, 16'h1234, 1'b1, "wr_0005");
    access(1'b0, 16'h0005, 16'h0000, 1'b1, "rd_0005");
  endtask

  task automatic test_io_write();
    access(1'b1, IO_ADDR, 16'hBEEF, 1'b1, "io_wr");
  endtask

  task automatic test_io_read();
    sw_i = 16'h00A5;
    repeat (2) @(posedge clk);
    #1;
    access(1'b0, IO_ADDR, 16'h0000, 1'b1, "io_rd");
  endtask

  task automatic test_alias();
    access(1'b1, 16'h0403, 16'h7777, 1'b1, "alias_wr");
    access(1'b0, 16'h0003, 16'h0000, 1'b1, "alias_rd");
  endtask

  task automatic test_back_to_back();
    access(1'b1, 16'h0020, 16'hA1A1, 1'b1, "b2b_wr");
    access(1'b0, 16'h0020, 16'h0000, 1'b0, "b2b_rd");
    access(1'b1, IO_ADDR,  16'h5A5A, 1'b0, "b2b_io");
  endtask

  task automatic test_reset_mid_busy();
    @(posedge clk); #1;
    mem_mem_ena = 1'b1; mem_wr_ena = 1'b0; mem_addr = 16'h0005;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (mem_rdy !== 1'b0 || bram_ena !== 1'b0) begin
        errors++; $display("FAIL abort cyc%0d rdy %b ena %b want 0 0", k, mem_rdy, bram_ena);
      end
    end
    checks++;
    if (hex_display_o !== 16'h0) begin errors++; $display("FAIL abort_hex got %h want 0000", hex_display_o); end
    mem_mem_ena = 1'b0;
    reset = 1'b0;
    exp_hex = 16'h0;
    access(1'b0, 16'h0005, 16'h0000, 1'b1, "rd_after_abort");
  endtask

  task automatic test_random();
    logic [15:0] pool [6];
    logic [15:0] a;
    bit          w;
    pool[0] = 16'h0005; pool[1] = 16'h0405; pool[2] = 16'h0003;
    pool[3] = 16'hFC03; pool[4] = IO_ADDR;  pool[5] = 16'h0100;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) a = 16'($urandom_range(0, 16'hFFFE));
      else                           a = pool[$urandom_range(0, 5)];
      w = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        sw_i = 16'($urandom);
        repeat (2) @(posedge clk);
        #1;
        access(w, a, 16'($urandom), 1'b1, "rand");
      end else begin
        access(w, a, 16'($urandom), bit'($urandom_range(0, 1)), "rand");
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]  = 16'h0;
      bram_mem[i] = 16'h0;
    end
    bram_addr_r = '0;
    exp_hex = 16'h0;
    sw_i = 16'h0;
    test_reset();
    test_write_read();
    test_io_write();
    test_io_read();
    test_alias();
    test_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
